// File: rtl/mips_pkg.sv
// Shared register-file types and constants for the writeback path.
package mips_pkg;
  localparam int NREG      = 32;
  localparam int REG_AW    = 5;
  localparam int DW        = 32;
  localparam int MAX_B_RUN = 4;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [DW-1:0]     word_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for long-latency writebacks, plus the
// RAW/WAW hazard compare that drives the issue stall.
module wb_scoreboard
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_iss_valid,
  input  logic            i_iss_long,
  input  logic            i_iss_wen,
  input  reg_idx_t        i_iss_dest,
  input  reg_idx_t        i_iss_src1,
  input  reg_idx_t        i_iss_src2,
  input  logic            i_b_accept,
  input  reg_idx_t        i_b_dest,
  output logic            o_iss_stall,
  output logic [NREG-1:0] o_pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic            w_hazard;
  logic            w_set;

  // Hazards are judged against the registered vector, so a clear from a
  // B accept only releases the stall on the following cycle.
  always_comb begin
    w_hazard = 1'b0;
    if (i_iss_src1 != REG_ZERO && r_pending[i_iss_src1]) w_hazard = 1'b1;
    if (i_iss_src2 != REG_ZERO && r_pending[i_iss_src2]) w_hazard = 1'b1;
    if (i_iss_wen && i_iss_dest != REG_ZERO && r_pending[i_iss_dest]) w_hazard = 1'b1;
  end

  assign o_iss_stall = i_iss_valid && w_hazard;
  assign w_set = i_iss_valid && !o_iss_stall && i_iss_long && i_iss_wen &&
                 (i_iss_dest != REG_ZERO);

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_set) w_set_mask[i_iss_dest] = 1'b1;
    if (i_b_accept && i_b_dest != REG_ZERO) w_clr_mask[i_b_dest] = 1'b1;
  end

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the ALU (A) and the
// long-latency unit (B), with a bounded B run so A cannot starve.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int P_NREG      = NREG,
  parameter int P_DW        = DW,
  parameter int P_MAX_B_RUN = MAX_B_RUN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_dest,
  input  logic [P_DW-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_dest,
  input  logic [P_DW-1:0]   b_data,
  input  logic              iss_valid,
  input  logic              iss_long,
  input  logic              iss_wen,
  input  logic [4:0]        iss_dest,
  input  logic [4:0]        iss_src1,
  input  logic [4:0]        iss_src2,
  output logic              iss_stall,
  output logic              wren,
  output logic [4:0]        wr,
  output logic [P_DW-1:0]   wd,
  output logic [P_NREG-1:0] pending
);

  localparam int RUN_W = $clog2(P_MAX_B_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(P_MAX_B_RUN);

  logic [RUN_W-1:0] r_run_cnt;
  logic             r_wren;
  logic [4:0]       r_wr;
  logic [P_DW-1:0]  r_wd;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_accept;
  logic [4:0]       w_dest;
  logic [P_DW-1:0]  w_data;
  logic [NREG-1:0]  w_pending;

  // Valid/ready: a request transfers in the cycle valid && ready is high;
  // the requester holds dest/data stable until then. Ready never depends
  // on anything registered except the B run counter.
  assign w_grant_b = b_valid && !(a_valid && r_run_cnt == RUN_MAX);
  assign w_grant_a = a_valid && !w_grant_b;
  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;

  assign w_accept = w_grant_a || w_grant_b;
  assign w_dest   = w_grant_b ? b_dest : a_dest;
  assign w_data   = w_grant_b ? b_data : a_data;

  // Counts B wins only while A is actually waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_cnt <= '0;
    end else if (!a_valid || w_grant_a) begin
      r_run_cnt <= '0;
    end else if (w_grant_b && r_run_cnt != RUN_MAX) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  // $0 writes are accepted but never strobe the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wren <= 1'b0;
      r_wr   <= '0;
      r_wd   <= '0;
    end else begin
      r_wren <= w_accept && (w_dest != REG_ZERO);
      if (w_accept) begin
        r_wr <= w_dest;
        r_wd <= w_data;
      end
    end
  end

  assign wren = r_wren;
  assign wr   = r_wr;
  assign wd   = r_wd;

  wb_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_iss_valid (iss_valid),
    .i_iss_long  (iss_long),
    .i_iss_wen   (iss_wen),
    .i_iss_dest  (iss_dest),
    .i_iss_src1  (iss_src1),
    .i_iss_src2  (iss_src2),
    .i_b_accept  (w_grant_b),
    .i_b_dest    (b_dest),
    .o_iss_stall (iss_stall),
    .o_pending   (w_pending)
  );

  assign pending = P_NREG'(w_pending);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus short random bench for regfile_wb_arbiter with an expected
// write queue and a reference model of grants and the pending vector.
module tb_regfile_wb_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_dest, b_dest;
  logic [31:0] a_data, b_data;
  logic        iss_valid, iss_long, iss_wen, iss_stall;
  logic [4:0]  iss_dest, iss_src1, iss_src2;
  logic        wren;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [31:0] pending;

  logic [36:0] exp_q[$];
  logic [31:0] m_pend;
  int          m_run;
  logic        g_a, g_b;
  int          n_pass, n_checks;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_wen(iss_wen),
    .iss_dest(iss_dest), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_stall(iss_stall), .wren(wren), .wr(wr), .wd(wd), .pending(pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && wren === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0 && {wr, wd} === exp_q[0]) n_pass++;
      else $error("FAIL write_port: observed %0h expected %0h (queued %0d)",
                  {wr, wd}, (exp_q.size() > 0) ? exp_q[0] : 37'h0, exp_q.size());
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // A scoreboard set and clear on the same index must never coincide.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      assert (!(iss_valid && !iss_stall && iss_long && iss_wen && iss_dest != 0 &&
                b_valid && b_ready && b_dest == iss_dest))
      else begin
        n_checks++;
        $error("FAIL set_clear_collision: index %0d", iss_dest);
      end
    end
  end

  // One arbitration cycle: check combinational outputs against the model,
  // queue expected writes, advance the model, then step past the edge.
  task automatic cycle();
    logic ea, eb, hz;
    @(negedge clk);
    chk("pending", pending, m_pend);
    eb = b_valid && !(a_valid && m_run == MAXB);
    ea = a_valid && !eb;
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    hz = (iss_src1 != 0 && m_pend[iss_src1]) || (iss_src2 != 0 && m_pend[iss_src2]) ||
         (iss_wen && iss_dest != 0 && m_pend[iss_dest]);
    chk("iss_stall", iss_stall, iss_valid && hz);
    if (ea && a_dest != 0) exp_q.push_back({a_dest, a_data});
    if (eb && b_dest != 0) exp_q.push_back({b_dest, b_data});
    if (!a_valid || ea) m_run = 0;
    else if (eb && m_run != MAXB) m_run++;
    if (eb && b_dest != 0) m_pend[b_dest] = 1'b0;
    if (iss_valid && !(iss_valid && hz) && iss_long && iss_wen && iss_dest != 0)
      m_pend[iss_dest] = 1'b1;
    g_a = ea;
    g_b = eb;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic lng, input logic wen,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    iss_valid = v; iss_long = lng; iss_wen = wen;
    iss_dest = d; iss_src1 = s1; iss_src2 = s2;
  endtask

  initial begin
    logic order_b [6];
    order_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    n_pass = 0; n_checks = 0; m_pend = '0; m_run = 0;
    rst = 1'b0;
    a_valid = 0; a_dest = 0; a_data = 0;
    b_valid = 0; b_dest = 0; b_data = 0;
    issue(0, 0, 0, 0, 0, 0);

    // Reset state and combinational readies while held in reset
    #3;
    chk("rst_wren", wren, 0);
    chk("rst_wr", wr, 0);
    chk("rst_wd", wd, 0);
    chk("rst_pending", pending, 0);
    chk("rst_stall", iss_stall, 0);
    a_valid = 1; #1;
    chk("rst_a_ready", a_ready, 1);
    a_valid = 0; b_valid = 1; #1;
    chk("rst_b_ready", b_ready, 1);
    b_valid = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // A only
    a_valid = 1; a_dest = 5; a_data = 32'hDEADBEEF;
    cycle();
    a_valid = 0;
    chk("a_wren", wren, 1);
    chk("a_wr", wr, 5);
    chk("a_wd", wd, 32'hDEADBEEF);
    cycle();
    chk("a_wren_drop", wren, 0);

    // RAW on a long op, released by its B writeback
    issue(1, 1, 1, 8, 0, 0);
    cycle();
    chk("pend8_set", pending, 32'h0000_0100);
    issue(1, 0, 1, 9, 8, 0);
    cycle();
    b_valid = 1; b_dest = 8; b_data = 32'h0808_0808;
    cycle();
    b_valid = 0;
    chk("pend8_clr", pending, 0);
    chk("raw_release", iss_stall, 0);
    cycle();
    issue(0, 0, 0, 0, 0, 0);

    // Both valid: B run capped at MAXB
    a_valid = 1; a_dest = 1; a_data = 32'hAAAA_0001;
    b_valid = 1; b_dest = 2; b_data = 32'hBBBB_0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("order_b", b_ready, order_b[i]);
      chk("one_ready", a_ready ^ b_ready, 1);
      @(posedge clk); #1;
      // replay the cycle through the model: rewind one edge is not possible,
      // so the model is advanced by hand for this directed window
      if (order_b[i]) begin
        exp_q.push_back({b_dest, b_data});
        m_run = (m_run == MAXB) ? MAXB : m_run + 1;
        b_data = $urandom;
      end else begin
        exp_q.push_back({a_dest, a_data});
        m_run = 0;
        a_data = $urandom;
      end
    end
    a_valid = 0; b_valid = 0;
    cycle();
    cycle();

    // $0 write and $0 long issue
    a_valid = 1; a_dest = 0; a_data = 32'h1234;
    cycle();
    a_valid = 0;
    chk("zero_wren", wren, 0);
    issue(1, 1, 1, 0, 0, 0);
    cycle();
    issue(0, 0, 0, 0, 0, 0);
    chk("zero_pend", pending, 0);

    // WAW on pending[3]
    issue(1, 1, 1, 3, 0, 0);
    cycle();
    issue(1, 1, 1, 3, 0, 0);
    cycle();
    chk("waw_pend", pending, 32'h0000_0008);
    issue(1, 0, 0, 0, 0, 3);
    cycle();
    issue(0, 0, 0, 0, 0, 0);
    b_valid = 1; b_dest = 3; b_data = 32'h0303_0303;
    cycle();
    b_valid = 0;

    // Reset while a write is in flight and bits are pending
    issue(1, 1, 1, 4, 0, 0);
    cycle();
    issue(1, 1, 1, 8, 0, 0);
    cycle();
    issue(0, 0, 0, 0, 0, 0);
    a_valid = 1; a_dest = 7; a_data = 32'hCAFEF00D;
    cycle();
    a_valid = 0;
    chk("pre_rst_wren", wren, 1);
    chk("pre_rst_pend", pending, 32'h0000_0110);
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk("async_wren", wren, 0);
    chk("async_pend", pending, 0);
    chk("async_wr", wr, 0);
    m_pend = '0; m_run = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic: requesters hold until accepted
    for (int i = 0; i < 40; i++) begin
      if (!a_valid || g_a) begin
        a_valid = 1'($urandom_range(0, 1)); a_dest = 5'($urandom_range(0, 31)); a_data = $urandom;
      end
      if (!b_valid || g_b) begin
        b_valid = 1'($urandom_range(0, 1)); b_dest = 5'($urandom_range(0, 31)); b_data = $urandom;
      end
      g_a = 0; g_b = 0;
      cycle();
    end
    a_valid = 0; b_valid = 0;
    cycle();
    cycle();
    chk("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
